// File: rtl/riscv_pkg.sv
// Shared types and widths for the RV32I pipeline: forward selects and the
// execute-stage control bundle carried from decode into EX.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // Forwarding-unit operand source; 2'b11 is reserved and behaves like FWD_RF.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Decode control bits that travel together into EX as one register.
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every signal between the ID/EX stage and its neighbours:
// decode inputs, pipeline control, forward sources and the EX outputs.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic            StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REGW-1:0] Rs1D, Rs2D, RdD;
  logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ALUResultM, ResultW;

  logic [REGW-1:0] Rs1E, Rs2E, RdE;
  logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] PCE, PCPlus4E, ImmExtE;
  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE;
  logic            ValidE;

  // Surrounding pipeline: drives decode/forward inputs, observes EX outputs.
  modport master (
    output StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, PCE, PCPlus4E, ImmExtE,
           SrcAE, SrcBE, WriteDataE, ValidE
  );

  // The ID/EX stage itself.
  modport slave (
    input  StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, PCE, PCPlus4E, ImmExtE,
           SrcAE, SrcBE, WriteDataE, ValidE
  );
endinterface

// File: rtl/fwd_operand_hold.sv
// One EX operand: 3:1 forward mux plus a capture register that freezes the
// forwarded value while EX is stalled, because the M/W producers keep
// draining and their values would otherwise vanish mid-operation.
module fwd_operand_hold
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      fwd_sel,
  input  logic [XLEN-1:0] rf_val,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] operand
);

  logic [XLEN-1:0] live;
  logic [XLEN-1:0] hold_val;
  logic            hold_valid;

  // Live forward selection; the reserved code falls through to the register file.
  always_comb begin
    // NOTE: default assigned first so no path leaves 'live' unassigned (no latch).
    live = rf_val;
    case (fwd_sel)
      FWD_W:   live = result_w;
      FWD_M:   live = alu_result_m;
      default: ;
    endcase
  end

  // Hold-valid flag: set on the first stall cycle, dropped when EX moves on.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset || flush)  hold_valid <= 1'b0;
    else if (stall)      hold_valid <= 1'b1;
    else                 hold_valid <= 1'b0;
  end

  // Captured operand, written only on the first stall cycle.
  always_ff @(posedge clk) begin
    // NOTE: no reset needed on the data itself; it is never used unless
    // hold_valid is set, and hold_valid is reset.
    if (stall && !hold_valid) hold_val <= live;
  end

  assign operand = hold_valid ? hold_val : live;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX operand selection for the 5-stage RV32I core.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  ex_ctrl_t        ctrl_d, ctrl_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [REGW-1:0] rs1_e, rs2_e, rd_e;
  logic            valid_e;
  logic [XLEN-1:0] op_a, op_b;

  assign ctrl_d = '{RegWrite:   bus.RegWriteD,
                    ResultSrc:  bus.ResultSrcD,
                    MemWrite:   bus.MemWriteD,
                    Jump:       bus.JumpD,
                    Branch:     bus.BranchD,
                    ALUControl: bus.ALUControlD,
                    ALUSrc:     bus.ALUSrcD};

  // Pipeline register: reset and flush make a bubble, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ctrl_e  <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      pc_e    <= '0;
      pc4_e   <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      valid_e <= 1'b0;
    end else if (!bus.StallE) begin
      ctrl_e  <= ctrl_d;
      rd1_e   <= bus.RD1D;
      rd2_e   <= bus.RD2D;
      imm_e   <= bus.ImmExtD;
      pc_e    <= bus.PCD;
      pc4_e   <= bus.PCPlus4D;
      rs1_e   <= bus.Rs1D;
      rs2_e   <= bus.Rs2D;
      rd_e    <= bus.RdD;
      valid_e <= 1'b1;
    end
  end

  fwd_operand_hold u_hold_a (
    .clk          (clk),
    .reset        (reset),
    .stall        (bus.StallE),
    .flush        (bus.FlushE),
    .fwd_sel      (bus.ForwardAE),
    .rf_val       (rd1_e),
    .alu_result_m (bus.ALUResultM),
    .result_w     (bus.ResultW),
    .operand      (op_a)
  );

  fwd_operand_hold u_hold_b (
    .clk          (clk),
    .reset        (reset),
    .stall        (bus.StallE),
    .flush        (bus.FlushE),
    .fwd_sel      (bus.ForwardBE),
    .rf_val       (rd2_e),
    .alu_result_m (bus.ALUResultM),
    .result_w     (bus.ResultW),
    .operand      (op_b)
  );

  assign bus.SrcAE       = op_a;
  assign bus.WriteDataE  = op_b;
  assign bus.SrcBE       = ctrl_e.ALUSrc ? imm_e : op_b;

  assign bus.RegWriteE   = ctrl_e.RegWrite;
  assign bus.ResultSrcE  = ctrl_e.ResultSrc;
  assign bus.MemWriteE   = ctrl_e.MemWrite;
  assign bus.JumpE       = ctrl_e.Jump;
  assign bus.BranchE     = ctrl_e.Branch;
  assign bus.ALUControlE = ctrl_e.ALUControl;
  assign bus.ALUSrcE     = ctrl_e.ALUSrc;
  assign bus.Rs1E        = rs1_e;
  assign bus.Rs2E        = rs2_e;
  assign bus.RdE         = rd_e;
  assign bus.PCE         = pc_e;
  assign bus.PCPlus4E    = pc4_e;
  assign bus.ImmExtE     = imm_e;
  assign bus.ValidE      = valid_e;

endmodule
